// File: rtl/boot_loader.sv
// Length-prefixed byte-stream loader: packs big-endian words into RAM
// and holds the CPU in reset until the whole image has been written.
module boot_loader #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MAX_WORDS      = 1024,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           words_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAY, S_WRITE, S_DONE, S_ERR
  } state_e;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

  state_e                  state_q, state_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic [31:0]             len_q, len_d;
  logic [15:0]             widx_q, widx_d;
  logic [15:0]             words_q, words_d;
  logic [31:0]             asm_q, asm_d;
  logic [31:0]             gap_q, gap_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic        xfer;
  logic        tmo;
  logic [31:0] len_nxt;
  logic [31:0] word_nxt;
  logic [15:0] widx_inc;

  assign rx_ready_o = (state_q == S_HDR) || (state_q == S_PAY);
  assign xfer       = rx_valid_i && rx_ready_o;
  assign tmo        = (TIMEOUT_CYCLES != 0) && (gap_q == TO_LAST);
  assign len_nxt    = {len_q[23:0], rx_data_i};
  assign word_nxt   = {asm_q[23:0], rx_data_i};
  assign widx_inc   = widx_q + 16'd1;

  assign mem_we_o   = (state_q == S_WRITE);
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign cpu_rst_o  = (state_q != S_DONE);
  assign busy_o     = (state_q == S_HDR) || (state_q == S_PAY)
                   || (state_q == S_WRITE);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = (state_q == S_ERR);
  assign words_o    = words_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    len_d   = len_q;
    widx_d  = widx_q;
    words_d = words_q;
    asm_d   = asm_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_HDR: begin
        if (xfer) begin
          len_d  = len_nxt;
          bcnt_d = bcnt_q + 2'd1;
          gap_d  = '0;
          if (bcnt_q == 2'd3) begin
            if (len_nxt == '0)          state_d = S_DONE;
            else if (len_nxt > MAX_LEN) state_d = S_ERR;
            else                        state_d = S_PAY;
          end
        end else if (tmo) begin
          state_d = S_ERR;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_PAY: begin
        if (xfer) begin
          asm_d  = word_nxt;
          bcnt_d = bcnt_q + 2'd1;
          gap_d  = '0;
          if (bcnt_q == 2'd3) begin
            data_d  = word_nxt;
            addr_d  = BASE_ADDR + ADDR_WIDTH'({widx_q, 2'b00});
            state_d = S_WRITE;
          end
        end else if (tmo) begin
          state_d = S_ERR;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_WRITE: begin
        widx_d  = widx_inc;
        words_d = words_q + 16'd1;
        state_d = ({16'd0, widx_inc} == len_q) ? S_DONE : S_PAY;
      end
      default: begin
        // IDLE, DONE and ERR all re-arm on start
        if (start_i) begin
          state_d = S_HDR;
          bcnt_d  = '0;
          len_d   = '0;
          widx_d  = '0;
          words_d = '0;
          gap_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      len_q   <= '0;
      widx_q  <= '0;
      words_q <= '0;
      asm_q   <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      words_q <= words_d;
      asm_q   <= asm_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected RAM writes are queued by the
// stimulus and popped by a negedge monitor whenever mem_we_o is seen.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_o;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  boot_loader #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .BASE_ADDR     (32'h0),
    .MAX_WORDS     (1024),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .rx_valid_i(rx_valid_i),
    .rx_data_i (rx_data_i),
    .rx_ready_o(rx_ready_o),
    .mem_we_o  (mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .cpu_rst_o (cpu_rst_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .words_o   (words_o)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: every write pulse must match the next queued write
  always @(negedge clk) begin
    if (!rst_i && mem_we_o) begin
      chk("ready_low_in_write", {31'd0, rx_ready_o}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h:%h required=none",
                 mem_addr_o, mem_data_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr_o, e[63:32]);
        chk("wr_data", mem_data_o, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    for (int i = 0; i < 50 && !got; i++) begin
      got = rx_ready_o;
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout actual=stalled required=%h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready",   {31'd0, rx_ready_o}, 32'd0);
    chk("rst_we",      {31'd0, mem_we_o},   32'd0);
    chk("rst_addr",    mem_addr_o,          32'd0);
    chk("rst_data",    mem_data_o,          32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst_o},  32'd1);
    chk("rst_busy",    {31'd0, busy_o},     32'd0);
    chk("rst_done",    {31'd0, done_o},     32'd0);
    chk("rst_err",     {31'd0, err_o},      32'd0);
    chk("rst_words",   {16'd0, words_o},    32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // two-word image, valid held high through the write cycles
    pulse_start();
    chk("t1_busy",  {31'd0, busy_o},     32'd1);
    chk("t1_ready", {31'd0, rx_ready_o}, 32'd1);
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    exp_q.push_back({32'h4, 32'h01020304});
    send_word(32'h00000002);
    send_word(32'hDEADBEEF);
    send_word(32'h01020304);
    rx_valid_i = 1'b0;
    chk("t1_done_early", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    chk("t1_done",    {31'd0, done_o},    32'd1);
    chk("t1_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
    chk("t1_busy_lo", {31'd0, busy_o},    32'd0);
    chk("t1_words",   {16'd0, words_o},   32'd2);

    // zero-length image completes straight from the header
    pulse_start();
    chk("t2_done_clr", {31'd0, done_o},    32'd0);
    chk("t2_cpu_rst",  {31'd0, cpu_rst_o}, 32'd1);
    chk("t2_words",    {16'd0, words_o},   32'd0);
    send_word(32'h00000000);
    rx_valid_i = 1'b0;
    chk("t2_done",    {31'd0, done_o},    32'd1);
    chk("t2_cpu_rel", {31'd0, cpu_rst_o}, 32'd0);

    // oversize header (1025 words) aborts
    pulse_start();
    send_word(32'h00000401);
    rx_valid_i = 1'b0;
    chk("t3_err",     {31'd0, err_o},     32'd1);
    chk("t3_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    chk("t3_busy",    {31'd0, busy_o},    32'd0);
    pulse_start();
    chk("t3_err_clr", {31'd0, err_o},      32'd0);
    chk("t3_hdr",     {31'd0, rx_ready_o}, 32'd1);

    // timeout: len=1, two payload bytes then silence
    send_word(32'h00000001);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rx_valid_i = 1'b0;
    repeat (15) @(negedge clk);
    chk("t4_err_pre", {31'd0, err_o}, 32'd0);
    @(negedge clk);
    chk("t4_err",     {31'd0, err_o},     32'd1);
    chk("t4_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    chk("t4_words",   {16'd0, words_o},   32'd0);

    // reset during the second word, then a one-word reload
    pulse_start();
    exp_q.push_back({32'h0, 32'h11223344});
    send_word(32'h00000002);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    rx_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_busy",  {31'd0, busy_o},     32'd0);
    chk("t6_rst_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("t6_rst_words", {16'd0, words_o},    32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    pulse_start();
    exp_q.push_back({32'h0, 32'hCAFEF00D});
    send_word(32'h00000001);
    send_word(32'hCAFEF00D);
    rx_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_done",  {31'd0, done_o},  32'd1);
    chk("t6_words", {16'd0, words_o}, 32'd1);

    repeat (2) @(negedge clk);
    chk("writes_outstanding", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
